// File: rtl/assign_trail.sv
// Assignment trail for a SAT solver: a LIFO of {var, val, level} entries
// that tracks the decision level and unwinds entries above a backtrack target.
module assign_trail #(
   parameter int VAR_NUM = 8,
   parameter int VAR_LOG = 3,
   parameter int LVL_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push_valid,
   input  logic [VAR_LOG-1:0] push_var,
   input  logic               push_val,
   input  logic               push_dec,
   output logic               push_ready,
   input  logic               bt_req,
   input  logic [LVL_W-1:0]   bt_level,
   output logic               pop_valid,
   output logic [VAR_LOG-1:0] pop_var,
   output logic               pop_val,
   input  logic               pop_ready,
   output logic               bt_done,
   output logic [LVL_W-1:0]   cur_level,
   output logic [VAR_LOG:0]   count,
   output logic               full,
   output logic               empty,
   output logic               ovf
);

   localparam int CNT_W = VAR_LOG + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UNWIND = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   count_q;
   logic [LVL_W-1:0]   cur_level_q;
   logic [LVL_W-1:0]   tgt_q;
   logic               ovf_q;

   logic [VAR_LOG-1:0] var_mem [VAR_NUM];
   logic               val_mem [VAR_NUM];
   logic [LVL_W-1:0]   lvl_mem [VAR_NUM];

   logic [VAR_LOG-1:0] top_idx_s;
   logic [VAR_LOG-1:0] wr_idx_s;
   logic [LVL_W-1:0]   lvl_d;
   logic               full_s;
   logic               empty_s;
   logic               push_ready_s;
   logic               push_fire_s;
   logic               pop_valid_s;
   logic               pop_fire_s;

   // Handshake and trail-top decode
   always_comb begin
      full_s       = (count_q == CNT_W'(VAR_NUM));
      empty_s      = (count_q == {CNT_W{1'b0}});
      top_idx_s    = VAR_LOG'(count_q - CNT_W'(1));
      wr_idx_s     = count_q[VAR_LOG-1:0];
      lvl_d        = push_dec ? (cur_level_q + LVL_W'(1)) : cur_level_q;
      push_ready_s = (state_q == ST_IDLE) && !full_s && !bt_req;
      push_fire_s  = push_valid && push_ready_s;
      // Entries at or below the target level survive the backtrack.
      pop_valid_s  = (state_q == ST_UNWIND) && !empty_s && (lvl_mem[top_idx_s] > tgt_q);
      pop_fire_s   = pop_valid_s && pop_ready;
   end

   // Entry storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (push_fire_s) begin
         var_mem[wr_idx_s] <= push_var;
         val_mem[wr_idx_s] <= push_val;
         lvl_mem[wr_idx_s] <= lvl_d;
      end
   end

   // Control FSM with count, level, target and overflow tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= {CNT_W{1'b0}};
         cur_level_q <= {LVL_W{1'b0}};
         tgt_q       <= {LVL_W{1'b0}};
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (push_valid && full_s) begin
                  ovf_q <= 1'b1;
               end
               if (bt_req) begin
                  tgt_q   <= bt_level;
                  state_q <= ST_UNWIND;
               end else if (push_fire_s) begin
                  count_q     <= count_q + CNT_W'(1);
                  cur_level_q <= lvl_d;
               end
            end
            ST_UNWIND: begin
               if (pop_fire_s) begin
                  count_q <= count_q - CNT_W'(1);
               end else if (!pop_valid_s) begin
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (tgt_q < cur_level_q) begin
                  cur_level_q <= tgt_q;
               end
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign push_ready = push_ready_s;
   assign pop_valid  = pop_valid_s;
   assign pop_var    = var_mem[top_idx_s];
   assign pop_val    = val_mem[top_idx_s];
   assign bt_done    = (state_q == ST_DONE);
   assign cur_level  = cur_level_q;
   assign count      = count_q;
   assign full       = full_s;
   assign empty      = empty_s;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_assign_trail.sv
// Scoreboard bench for assign_trail: a queue-based trail model predicts pops,
// levels and backtrack latency; a monitor checks popped entries independently.
module tb_assign_trail;

   localparam int VAR_NUM = 8;
   localparam int VAR_LOG = 3;
   localparam int LVL_W   = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               push_valid = 1'b0;
   logic [VAR_LOG-1:0] push_var = '0;
   logic               push_val = 1'b0;
   logic               push_dec = 1'b0;
   logic               push_ready;
   logic               bt_req = 1'b0;
   logic [LVL_W-1:0]   bt_level = '0;
   logic               pop_valid;
   logic [VAR_LOG-1:0] pop_var;
   logic               pop_val;
   logic               pop_ready = 1'b0;
   logic               bt_done;
   logic [LVL_W-1:0]   cur_level;
   logic [VAR_LOG:0]   count;
   logic               full;
   logic               empty;
   logic               ovf;

   typedef struct {
      int v;
      int b;
      int l;
   } ent_t;

   ent_t mq[$];
   int   exp_q[$];
   int   mlevel = 0;
   bit   movf = 1'b0;
   bit   bt_active = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   bit   hold_v = 1'b0;
   int   hold_e = 0;

   assign_trail #(.VAR_NUM(VAR_NUM), .VAR_LOG(VAR_LOG), .LVL_W(LVL_W)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_var(push_var), .push_val(push_val),
      .push_dec(push_dec), .push_ready(push_ready),
      .bt_req(bt_req), .bt_level(bt_level),
      .pop_valid(pop_valid), .pop_var(pop_var), .pop_val(pop_val),
      .pop_ready(pop_ready), .bt_done(bt_done), .cur_level(cur_level),
      .count(count), .full(full), .empty(empty), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted pop must match the predicted order
   always @(negedge clk) begin
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("pop_hold", {pop_valid, pop_var, pop_val}, {1'b1, hold_e[VAR_LOG:0]});
         end
         if (pop_valid && pop_ready) begin
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", {pop_var, pop_val}, 32'hFFFF);
            end else begin
               chk("pop_entry", {pop_var, pop_val}, exp_q.pop_front());
            end
         end
         hold_v = pop_valid && !pop_ready;
         hold_e = {pop_var, pop_val};
         if (bt_done) begin
            chk("bt_done_expected", 1, bt_active);
            chk("pops_drained", exp_q.size(), 0);
         end
      end
   end

   task automatic check_state();
      int n;
      n = mq.size();
      chk("count", count, n);
      chk("cur_level", cur_level, mlevel);
      chk("empty", empty, (n == 0));
      chk("full", full, (n == VAR_NUM));
      chk("ovf", ovf, movf);
      chk("push_ready_idle", push_ready, (n != VAR_NUM));
      chk("pop_valid_idle", pop_valid, 0);
      chk("bt_done_idle", bt_done, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      mq.delete(); exp_q.delete();
      mlevel = 0; movf = 1'b0; bt_active = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); check_state();
   endtask

   task automatic do_push(input int v, input int b, input int d);
      bit   rdy;
      ent_t e;
      @(posedge clk); #1;
      push_valid = 1'b1; push_var = VAR_LOG'(v); push_val = b[0]; push_dec = d[0];
      @(negedge clk);
      rdy = (mq.size() < VAR_NUM);
      chk("push_ready", push_ready, rdy);
      @(posedge clk); #1 push_valid = 1'b0;
      if (rdy) begin
         e.v = v; e.b = b; e.l = mlevel + d;
         mlevel = e.l;
         mq.push_back(e);
      end else begin
         movf = 1'b1;
      end
      @(negedge clk); check_state();
   endtask

   // mode 0: pop_ready held high, 1: toggles 1/0, 2: random
   task automatic do_bt(input int lvl, input int mode, input bit with_push);
      int n;
      int cyc;
      bit done;
      n = 0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].l <= lvl) break;
         exp_q.push_back(mq[i].v * 2 + mq[i].b);
         n++;
      end
      @(posedge clk); #1;
      bt_req = 1'b1; bt_level = LVL_W'(lvl); bt_active = 1'b1;
      if (with_push) begin
         push_valid = 1'b1; push_var = VAR_LOG'($urandom); push_val = 1'b1; push_dec = 1'b1;
      end
      @(negedge clk);
      if (with_push) chk("push_ready_bt", push_ready, 0);
      @(posedge clk); #1;
      bt_req = 1'b0; push_valid = 1'b0;
      cyc = 1; done = 1'b0;
      while (!done && cyc < 64) begin
         if (mode == 0) pop_ready = 1'b1;
         else if (mode == 1) pop_ready = (cyc % 2 == 1);
         else pop_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (bt_done) begin
            done = 1'b1;
         end else begin
            @(posedge clk); #1 cyc++;
         end
      end
      chk("bt_done_seen", done, 1);
      if (mode == 0) chk("bt_latency", cyc, n + 2);
      repeat (n) void'(mq.pop_back());
      if (lvl < mlevel) mlevel = lvl;
      @(posedge clk); #1 pop_ready = 1'b0; bt_active = 1'b0;
      @(negedge clk); check_state();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); check_state();

      // Basic trail and full unwind to level 0
      do_push(3, 1, 1); do_push(5, 0, 0); do_push(1, 1, 1);
      chk("level_after_three", cur_level, 2);
      do_bt(0, 0, 1'b0);
      chk("count_after_unwind", count, 0);

      // Same trail: backtrack above current level with a colliding push, then to level 1
      do_push(3, 1, 1); do_push(5, 0, 0); do_push(1, 1, 1);
      do_bt(3, 0, 1'b1);
      chk("count_no_pop", count, 3);
      do_bt(1, 1, 1'b0);
      chk("count_partial", count, 2);
      chk("level_partial", cur_level, 1);

      // Fill to capacity then overflow
      do_reset();
      for (int i = 0; i < VAR_NUM; i++) do_push(i, i % 2, 1);
      do_push(7, 0, 0);
      chk("ovf_set", ovf, 1);
      chk("count_full", count, VAR_NUM);

      // Randomised mix of pushes and backtracks
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 2) != 0) begin
            do_push($urandom_range(0, VAR_NUM - 1), $urandom_range(0, 1), $urandom_range(0, 1));
         end else begin
            do_bt($urandom_range(0, (mlevel + 1 > 15) ? 15 : mlevel + 1),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         end
      end

      // Reset in the middle of an unwind after one pop
      do_reset();
      do_push(2, 1, 1); do_push(6, 0, 1);
      exp_q.push_back(6 * 2 + 0); exp_q.push_back(2 * 2 + 1);
      bt_active = 1'b1;
      @(posedge clk); #1 bt_req = 1'b1; bt_level = '0;
      @(posedge clk); #1 bt_req = 1'b0; pop_ready = 1'b1;
      @(posedge clk); #1 pop_ready = 1'b0;
      @(negedge clk); chk("count_one_popped", count, 1);
      @(posedge clk); #1 rst = 1'b1;
      exp_q.delete(); mq.delete(); mlevel = 0; movf = 1'b0; bt_active = 1'b0;
      @(negedge clk); check_state();
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("no_done_after_rst", bt_done, 0);
      end
      check_state();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
